// File: rtl/sigmoid_err_pkg.sv
// sigmoid_err_pkg
// Shared definitions for the sigmoid/error unit:
//   - batch FSM state encoding
//   - PLAN breakpoints and offsets, expressed in Q.QM fixed point
//   - saturation limits for a signed word of a given width
//   - width helper for the channel index port
package sigmoid_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Breakpoints on a = |x| (QM >= 5 so every constant is an exact integer).
  function automatic int plan_bp_hi(input int qm);   // 5.0
    return 5 << qm;
  endfunction

  function automatic int plan_bp_mid(input int qm);  // 2.375 = 19/8
    return 19 << (qm - 3);
  endfunction

  function automatic int plan_bp_lo(input int qm);   // 1.0
    return 1 << qm;
  endfunction

  // Segment offsets.
  function automatic int plan_off_hi(input int qm);  // 0.84375 = 27/32
    return 27 << (qm - 5);
  endfunction

  function automatic int plan_off_mid(input int qm); // 0.625 = 5/8
    return 5 << (qm - 3);
  endfunction

  function automatic int plan_off_lo(input int qm);  // 0.5
    return 1 << (qm - 1);
  endfunction

  function automatic int plan_one(input int qm);     // 1.0
    return 1 << qm;
  endfunction

  // Signed saturation limits for a bw-bit word.
  function automatic longint sat_hi(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

  // Channel index width; one bit even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sigmoid_err_unit_plan.sv
// plan_sigmoid
// Combinational PLAN (piecewise-linear) sigmoid, shifts and adds only.
// Ports:
//   x_i  signed Q(BITWIDTH-QM).QM input
//   y_o  sigmoid(x_i), always in [0, 1.0]
module plan_sigmoid
  import sigmoid_err_pkg::*;
#(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11
) (
  input  logic signed [BITWIDTH-1:0] x_i,
  output logic        [BITWIDTH-1:0] y_o
);

  localparam logic [BITWIDTH-1:0] BP_HI    = BITWIDTH'(plan_bp_hi(QM));
  localparam logic [BITWIDTH-1:0] BP_MID   = BITWIDTH'(plan_bp_mid(QM));
  localparam logic [BITWIDTH-1:0] BP_LO    = BITWIDTH'(plan_bp_lo(QM));
  localparam logic [BITWIDTH-1:0] OFF_HI   = BITWIDTH'(plan_off_hi(QM));
  localparam logic [BITWIDTH-1:0] OFF_MID  = BITWIDTH'(plan_off_mid(QM));
  localparam logic [BITWIDTH-1:0] OFF_LO   = BITWIDTH'(plan_off_lo(QM));
  localparam logic [BITWIDTH-1:0] ONE      = BITWIDTH'(plan_one(QM));
  localparam logic [BITWIDTH-1:0] MOST_NEG = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0] MOST_POS = {1'b0, {(BITWIDTH-1){1'b1}}};

  logic [BITWIDTH-1:0] a_s;
  logic [BITWIDTH-1:0] y_abs_s;

  // Magnitude, PWL segment select, and mirror for negative inputs.
  always_comb begin
    // The most negative value has no positive twin; use the largest positive.
    if (x_i == MOST_NEG) begin
      a_s = MOST_POS;
    end else if (x_i[BITWIDTH-1]) begin
      a_s = -x_i;
    end else begin
      a_s = x_i;
    end

    if (a_s >= BP_HI) begin
      y_abs_s = ONE;
    end else if (a_s >= BP_MID) begin
      y_abs_s = (a_s >> 5) + OFF_HI;
    end else if (a_s >= BP_LO) begin
      y_abs_s = (a_s >> 3) + OFF_MID;
    end else begin
      y_abs_s = (a_s >> 2) + OFF_LO;
    end

    if (x_i[BITWIDTH-1]) begin
      y_o = ONE - y_abs_s;
    end else begin
      y_o = y_abs_s;
    end
  end

endmodule

// File: rtl/sigmoid_err_unit.sv
// sigmoid_err_unit
// Batch unit: on start, latches NCH pre-activations/targets and a shift, then
// streams one channel per cycle through a 2-stage pipeline producing
// sigmoid(x) and the saturated, scaled error (target - sigmoid) * 2**shift.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 begin a batch (accepted only in IDLE)
//   x_in, target_in       NCH packed signed words, channel k at [k*BITWIDTH +: BITWIDTH]
//   shift                 signed exponent (+ = left, - = arithmetic right)
//   busy                  batch in progress
//   out_valid/out_ch      result strobe and its channel index
//   sig_out, err_out      sigmoid and scaled error, held while out_valid = 0
//   done                  one-cycle pulse after the last result
module sigmoid_err_unit
  import sigmoid_err_pkg::*;
#(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11,
  parameter int NCH      = 4,
  parameter int SHW      = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NCH*BITWIDTH-1:0]      x_in,
  input  logic [NCH*BITWIDTH-1:0]      target_in,
  input  logic [SHW-1:0]               shift,
  output logic                         busy,
  output logic                         out_valid,
  output logic [ch_width(NCH)-1:0]     out_ch,
  output logic [BITWIDTH-1:0]          sig_out,
  output logic [BITWIDTH-1:0]          err_out,
  output logic                         done
);

  localparam int CHW = ch_width(NCH);
  // Wide enough for a (BITWIDTH+1)-bit error shifted left by BITWIDTH-1.
  localparam int WW  = 2 * BITWIDTH + 1;
  localparam logic [CHW-1:0]         LAST_CH = CHW'(NCH - 1);
  localparam logic signed [WW-1:0]   SAT_HI  = WW'(sat_hi(BITWIDTH));
  localparam logic signed [WW-1:0]   SAT_LO  = WW'(sat_lo(BITWIDTH));

  state_e                    state_q, state_d;
  logic [CHW-1:0]            cnt_q, cnt_d;
  logic                      hold_q, hold_d;
  logic                      load_s, issue_s;

  logic [NCH*BITWIDTH-1:0]   x_lat_q, tgt_lat_q;
  logic [SHW-1:0]            shift_lat_q;

  logic                      iss_vld_q;
  logic [CHW-1:0]            iss_ch_q;
  logic [BITWIDTH-1:0]       iss_x_q, iss_tgt_q;

  logic [BITWIDTH-1:0]       sig_s;
  logic                      s1_vld_q;
  logic [CHW-1:0]            s1_ch_q;
  logic [BITWIDTH-1:0]       s1_sig_q, s1_tgt_q;

  logic signed [31:0]        sh_s;
  logic                      left_s;
  logic [31:0]               shamt_s;
  logic signed [BITWIDTH:0]  err_s;
  logic signed [WW-1:0]      ext_s, shifted_s;
  logic [BITWIDTH-1:0]       err_sat_s;

  logic                      out_valid_q;
  logic [CHW-1:0]            out_ch_q;
  logic [BITWIDTH-1:0]       sig_out_q, err_out_q;

  // Batch FSM: accept start, issue channels, wait for the pipeline to empty.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    issue_s = 1'b0;
    // A start level that launched a batch must drop before it can launch another.
    hold_d  = start ? hold_q : 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !hold_q) begin
          load_s  = 1'b1;
          hold_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        issue_s = 1'b1;
        if (cnt_q == LAST_CH) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d   = cnt_q + CHW'(1);
        end
      end
      DRAIN: begin
        if (out_valid_q && (out_ch_q == LAST_CH)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, channel counter and start re-arm flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Batch operand latch; inputs are ignored until the next accepted start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_lat_q     <= '0;
      tgt_lat_q   <= '0;
      shift_lat_q <= '0;
    end else if (load_s) begin
      x_lat_q     <= x_in;
      tgt_lat_q   <= target_in;
      shift_lat_q <= shift;
    end else begin
      x_lat_q     <= x_lat_q;
      tgt_lat_q   <= tgt_lat_q;
      shift_lat_q <= shift_lat_q;
    end
  end

  // Issue register: one channel selected per RUN cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iss_vld_q <= 1'b0;
      iss_ch_q  <= '0;
      iss_x_q   <= '0;
      iss_tgt_q <= '0;
    end else begin
      iss_vld_q <= issue_s;
      iss_ch_q  <= cnt_q;
      iss_x_q   <= x_lat_q[cnt_q*BITWIDTH +: BITWIDTH];
      iss_tgt_q <= tgt_lat_q[cnt_q*BITWIDTH +: BITWIDTH];
    end
  end

  plan_sigmoid #(
    .BITWIDTH (BITWIDTH),
    .QM       (QM)
  ) u_plan (
    .x_i (iss_x_q),
    .y_o (sig_s)
  );

  // Stage 1: register the PWL sigmoid alongside its target.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_ch_q  <= '0;
      s1_sig_q <= '0;
      s1_tgt_q <= '0;
    end else begin
      s1_vld_q <= iss_vld_q;
      s1_ch_q  <= iss_ch_q;
      s1_sig_q <= sig_s;
      s1_tgt_q <= iss_tgt_q;
    end
  end

  // Stage 2 datapath: subtract at BITWIDTH+1 bits, clamp the shift, shift, saturate.
  always_comb begin
    sh_s = 32'($signed(shift_lat_q));
    if (sh_s >= BITWIDTH) begin
      sh_s = BITWIDTH - 1;
    end else if (sh_s <= -BITWIDTH) begin
      sh_s = -(BITWIDTH - 1);
    end else begin
      sh_s = sh_s;
    end
    left_s  = (sh_s >= 0);
    shamt_s = left_s ? 32'(sh_s) : 32'(-sh_s);

    err_s = $signed({s1_tgt_q[BITWIDTH-1], s1_tgt_q}) - $signed({1'b0, s1_sig_q});
    ext_s = {{(WW-BITWIDTH-1){err_s[BITWIDTH]}}, err_s};
    if (left_s) begin
      shifted_s = ext_s <<< shamt_s;
    end else begin
      shifted_s = ext_s >>> shamt_s;
    end

    if (shifted_s > SAT_HI) begin
      err_sat_s = SAT_HI[BITWIDTH-1:0];
    end else if (shifted_s < SAT_LO) begin
      err_sat_s = SAT_LO[BITWIDTH-1:0];
    end else begin
      err_sat_s = shifted_s[BITWIDTH-1:0];
    end
  end

  // Stage 2 / output registers; result fields hold between valid cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      sig_out_q   <= '0;
      err_out_q   <= '0;
    end else if (s1_vld_q) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= s1_ch_q;
      sig_out_q   <= s1_sig_q;
      err_out_q   <= err_sat_s;
    end else begin
      out_valid_q <= 1'b0;
      out_ch_q    <= out_ch_q;
      sig_out_q   <= sig_out_q;
      err_out_q   <= err_out_q;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign sig_out   = sig_out_q;
  assign err_out   = err_out_q;

endmodule

// File: tb/tb_sigmoid_err_unit.sv
module tb_sigmoid_err_unit;

  localparam int BW  = 18;
  localparam int NCH = 4;
  localparam int SHW = 6;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [NCH*BW-1:0]   x_in;
  logic [NCH*BW-1:0]   target_in;
  logic [SHW-1:0]      shift;
  logic                busy;
  logic                out_valid;
  logic [1:0]          out_ch;
  logic [BW-1:0]       sig_out;
  logic [BW-1:0]       err_out;
  logic                done;

  sigmoid_err_unit #(
    .BITWIDTH (BW),
    .QM       (11),
    .NCH      (NCH),
    .SHW      (SHW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .target_in (target_in),
    .shift     (shift),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .sig_out   (sig_out),
    .err_out   (err_out),
    .done      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [BW-1:0]  x;
    logic [BW-1:0]  tgt;
    logic [SHW-1:0] sh;
    logic [BW-1:0]  sig;
    logic [BW-1:0]  err;
  } vec_t;

  typedef struct {
    logic [1:0]    ch;
    logic [BW-1:0] sig;
    logic [BW-1:0] err;
  } exp_t;

  vec_t vecs[24];
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n, valid_cnt, done_cnt, first_valid, last_valid, done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: wait for the falling edge, then score whatever the DUT shows.
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    cyc_n++;
    if (out_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc_n;
      last_valid = cyc_n;
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e.ch));
        check("sig_out", 32'(sig_out), 32'(e.sig));
        check("err_out", 32'(err_out), 32'(e.err));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  task automatic load_batch(input int b);
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      x_in[k*BW +: BW]      = vecs[b*NCH+k].x;
      target_in[k*BW +: BW] = vecs[b*NCH+k].tgt;
      e.ch  = 2'(k);
      e.sig = vecs[b*NCH+k].sig;
      e.err = vecs[b*NCH+k].err;
      exp_q.push_back(e);
    end
    shift = vecs[b*NCH].sh;
  endtask

  // Run one batch for a fixed window and check its timing envelope.
  task automatic run_batch(input int b, input int hold, input bit garble, input bit poke);
    load_batch(b);
    start       = 1'b1;
    cyc_n       = 0;
    valid_cnt   = 0;
    done_cnt    = 0;
    first_valid = -1;
    last_valid  = -1;
    done_cyc    = -1;
    for (int i = 0; i < 22; i++) begin
      cyc();
      if (cyc_n == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (cyc_n == hold) start = 1'b0;
      if (garble && cyc_n == 1) begin
        x_in      = 72'({$urandom(), $urandom(), $urandom()});
        target_in = 72'({$urandom(), $urandom(), $urandom()});
        shift     = 6'($urandom());
      end
      if (poke && cyc_n == 8) start = 1'b1;
      if (poke && cyc_n == 9) start = 1'b0;
    end
    start = 1'b0;
    check("first_valid_cycle", 32'(first_valid), 32'd4);
    check("last_valid_cycle", 32'(last_valid), 32'd7);
    check("valid_count", 32'(valid_cnt), 32'd4);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'd8);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit saw_ch1;

    // x, target, shift, expected sigmoid, expected error
    vecs[0]  = '{18'h00000, 18'h00800, 6'd0,  18'h00400, 18'h00400};
    vecs[1]  = '{18'h0212F, 18'h00000, 6'd0,  18'h007C9, 18'h3F837};
    vecs[2]  = '{18'h3F800, 18'h00200, 6'd0,  18'h00200, 18'h00000};
    vecs[3]  = '{18'h1FFFF, 18'h00000, 6'd0,  18'h00800, 18'h3F800};
    vecs[4]  = '{18'h00000, 18'h00800, 6'd1,  18'h00400, 18'h00800};
    vecs[5]  = '{18'h20000, 18'h1FFFF, 6'd1,  18'h00000, 18'h1FFFF};
    vecs[6]  = '{18'h00800, 18'h00000, 6'd1,  18'h00600, 18'h3F400};
    vecs[7]  = '{18'h01000, 18'h00800, 6'd1,  18'h00700, 18'h00200};
    vecs[8]  = '{18'h00000, 18'h00800, 6'h3F, 18'h00400, 18'h00200};
    vecs[9]  = '{18'h01300, 18'h00000, 6'h3F, 18'h00758, 18'h3FC54};
    vecs[10] = '{18'h02800, 18'h01000, 6'h3F, 18'h00800, 18'h00400};
    vecs[11] = '{18'h3FC00, 18'h00300, 6'h3F, 18'h00300, 18'h00000};
    vecs[12] = '{18'h20000, 18'h1FFFF, 6'd3,  18'h00000, 18'h1FFFF};
    vecs[13] = '{18'h1FFFF, 18'h20000, 6'd3,  18'h00800, 18'h20000};
    vecs[14] = '{18'h00000, 18'h00400, 6'd3,  18'h00400, 18'h00000};
    vecs[15] = '{18'h027FF, 18'h00800, 6'd3,  18'h007FF, 18'h00008};
    vecs[16] = '{18'h00000, 18'h00800, 6'd31, 18'h00400, 18'h1FFFF};
    vecs[17] = '{18'h00000, 18'h00000, 6'd31, 18'h00400, 18'h20000};
    vecs[18] = '{18'h00000, 18'h00400, 6'd31, 18'h00400, 18'h00000};
    vecs[19] = '{18'h3F000, 18'h00101, 6'd31, 18'h00100, 18'h1FFFF};
    vecs[20] = '{18'h00000, 18'h00800, 6'h20, 18'h00400, 18'h00000};
    vecs[21] = '{18'h00000, 18'h00000, 6'h20, 18'h00400, 18'h3FFFF};
    vecs[22] = '{18'h00000, 18'h1FFFF, 6'h20, 18'h00400, 18'h00000};
    vecs[23] = '{18'h1FFFF, 18'h20000, 6'h20, 18'h00800, 18'h3FFFE};

    reset     = 1'b1;
    start     = 1'b0;
    x_in      = '0;
    target_in = '0;
    shift     = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out_ch", 32'(out_ch), 32'd0);
    check("reset_sig_out", 32'(sig_out), 32'd0);
    check("reset_err_out", 32'(err_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_batch(0, 1, 1'b0, 1'b0);
    run_batch(1, 1, 1'b1, 1'b0);   // inputs scrambled mid-batch
    run_batch(2, 20, 1'b0, 1'b0);  // start held high throughout
    run_batch(3, 1, 1'b0, 1'b1);   // start pulsed during done
    run_batch(4, 1, 1'b0, 1'b0);
    run_batch(5, 1, 1'b0, 1'b0);

    // Abort: reset while channel 1 is on the outputs.
    load_batch(0);
    start   = 1'b1;
    cyc_n   = 0;
    saw_ch1 = 1'b0;
    first_valid = -1;
    for (int i = 0; i < 12 && !saw_ch1; i++) begin
      cyc();
      start = 1'b0;
      if (out_valid && out_ch == 2'd1) saw_ch1 = 1'b1;
    end
    check("abort_reached_ch1", 32'(saw_ch1), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_ch", 32'(out_ch), 32'd0);
    check("abort_sig_out", 32'(sig_out), 32'd0);
    check("abort_err_out", 32'(err_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    valid_cnt = 0;
    done_cnt  = 0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    check("abort_no_valid", 32'(valid_cnt), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    run_batch(1, 1, 1'b0, 1'b0);   // fresh batch after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
